hcms_serial_rx: RTL and testbench

Synthesizable receiver for the HCMS-29xx serial write interface: data, clock, register select, active-low chip enable and active-low reset. It oversamples these lines on the system clock and reconstructs dot-data bytes and control-word writes. It sits on PMOD inputs and serves as an on-FPGA display model, letting `hcms_serial`/`hcms29xx` traffic be looped back and checked in hardware and simulation.

---
 rtl/hcms_serial_rx.sv | 136 +++++++++++++
 tb/tb_hcms_serial_rx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hcms_serial_rx.sv
// HCMS-29xx serial write receiver: oversamples the display's serial lines and
// rebuilds dot-data bytes and control-word writes, acting as an on-FPGA display model.
module hcms_serial_rx #(
  parameter logic [7:0] CTRL0_RESET = 8'h00,
  parameter logic [7:0] CTRL1_RESET = 8'h80
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_hcms_data,
  input  logic       i_hcms_clock,
  input  logic       i_hcms_regsel,
  input  logic       i_hcms_ncs,
  input  logic       i_hcms_reset,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  output logic [7:0] o_ctrl0,
  output logic [7:0] o_ctrl1,
  output logic [3:0] o_brightness,
  output logic [1:0] o_peak_current,
  output logic       o_sleep_n,
  output logic       o_ctrl_valid,
  output logic       o_frame_err
);

  typedef enum logic [1:0] {IDLE, FRAME, RESET_HOLD} state_t;

  // Line order in the sync vectors: {reset, ncs, regsel, clock, data}
  localparam logic [4:0] SYNC_IDLE = 5'b11000;

  logic [4:0] raw_lines;
  logic [4:0] sync1;
  logic [4:0] sync2;
  logic [4:0] hist;
  logic       clk_rise;
  logic       ncs_fall;
  logic       ncs_rise;

  state_t     state;
  logic [7:0] shift;
  logic [5:0] cnt;
  logic [7:0] shift_upd;
  logic [5:0] cnt_upd;

  assign raw_lines = {i_hcms_reset, i_hcms_ncs, i_hcms_regsel, i_hcms_clock, i_hcms_data};

  // Edge flags are registered so they line up with hist, which then carries the matching levels
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      sync1    <= SYNC_IDLE;
      sync2    <= SYNC_IDLE;
      hist     <= SYNC_IDLE;
      clk_rise <= 1'b0;
      ncs_fall <= 1'b0;
      ncs_rise <= 1'b0;
    end else begin
      sync1    <= raw_lines;
      sync2    <= sync1;
      hist     <= sync2;
      clk_rise <= sync2[1] & ~hist[1];
      ncs_fall <= ~sync2[3] & hist[3];
      ncs_rise <= sync2[3] & ~hist[3];
    end
  end

  always_comb begin
    shift_upd = shift;
    cnt_upd   = cnt;
    if (clk_rise) begin
      shift_upd = {shift[6:0], hist[0]};
      cnt_upd   = (cnt == 6'd63) ? cnt : cnt + 6'd1;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state        <= IDLE;
      shift        <= 8'h00;
      cnt          <= 6'd0;
      o_data       <= 8'h00;
      o_data_valid <= 1'b0;
      o_ctrl0      <= CTRL0_RESET;
      o_ctrl1      <= CTRL1_RESET;
      o_ctrl_valid <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_data_valid <= 1'b0;
      o_ctrl_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      if (!hist[4]) begin
        state   <= RESET_HOLD;
        o_ctrl0 <= CTRL0_RESET;
        o_ctrl1 <= CTRL1_RESET;
        shift   <= 8'h00;
        cnt     <= 6'd0;
      end else begin
        case (state)
          IDLE: begin
            if (ncs_fall) begin
              shift <= 8'h00;
              cnt   <= 6'd0;
              state <= FRAME;
            end
          end
          FRAME: begin
            shift <= shift_upd;
            cnt   <= cnt_upd;
            // A saturated count never wraps, so no further bytes come out past 63 bits
            if (clk_rise && !hist[2] && (cnt_upd[2:0] == 3'd0)) begin
              o_data       <= shift_upd;
              o_data_valid <= 1'b1;
            end
            if (ncs_rise) begin
              state <= IDLE;
              if (cnt_upd != 6'd0) begin
                if (cnt_upd[2:0] != 3'd0) begin
                  o_frame_err <= 1'b1;
                end else if (hist[2]) begin
                  if (shift_upd[7]) o_ctrl1 <= shift_upd;
                  else              o_ctrl0 <= shift_upd;
                  o_ctrl_valid <= 1'b1;
                end
              end
            end
          end
          RESET_HOLD: state <= IDLE;
          default:    state <= IDLE;
        endcase
      end
    end
  end

  assign o_brightness   = o_ctrl0[3:0];
  assign o_peak_current = o_ctrl0[5:4];
  assign o_sleep_n      = o_ctrl0[6];

endmodule

// File: tb/tb_hcms_serial_rx.sv
// Scoreboard bench for hcms_serial_rx: a bit-list model predicts bytes, control
// writes and frame errors with their arrival cycle; a monitor checks each DUT pulse.
module tb_hcms_serial_rx;

  logic       i_CLK = 1'b0;
  logic       i_RST;
  logic       i_hcms_data;
  logic       i_hcms_clock;
  logic       i_hcms_regsel;
  logic       i_hcms_ncs;
  logic       i_hcms_reset;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic [7:0] o_ctrl0;
  logic [7:0] o_ctrl1;
  logic [3:0] o_brightness;
  logic [1:0] o_peak_current;
  logic       o_sleep_n;
  logic       o_ctrl_valid;
  logic       o_frame_err;

  hcms_serial_rx #(.CTRL0_RESET(8'h00), .CTRL1_RESET(8'h80)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST),
    .i_hcms_data(i_hcms_data), .i_hcms_clock(i_hcms_clock),
    .i_hcms_regsel(i_hcms_regsel), .i_hcms_ncs(i_hcms_ncs),
    .i_hcms_reset(i_hcms_reset),
    .o_data(o_data), .o_data_valid(o_data_valid),
    .o_ctrl0(o_ctrl0), .o_ctrl1(o_ctrl1),
    .o_brightness(o_brightness), .o_peak_current(o_peak_current),
    .o_sleep_n(o_sleep_n), .o_ctrl_valid(o_ctrl_valid), .o_frame_err(o_frame_err)
  );

  always #5 i_CLK = ~i_CLK;

  int cyc = 0;
  always @(posedge i_CLK) cyc <= cyc + 1;

  typedef enum logic [1:0] {EV_DATA, EV_CTRL, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] a;
    logic [7:0] b;
    int         when;
  } ev_t;

  ev_t        exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] m_ctrl0;
  logic [7:0] m_ctrl1;
  bit         m_bits[$];
  bit         m_regsel;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expectEvent(input ev_kind_t k, input logic [7:0] a, input logic [7:0] b);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL unexpected pulse: got kind %0d, expected none (cycle %0d)", k, cyc);
    end else begin
      e = exp_q.pop_front();
      checkOutput("event kind", 32'(k), 32'(e.kind));
      checkOutput("event cycle", 32'(cyc), 32'(e.when));
      if (e.kind == EV_DATA) checkOutput("o_data", 32'(a), 32'(e.a));
      if (e.kind == EV_CTRL) begin
        checkOutput("o_ctrl0", 32'(a), 32'(e.a));
        checkOutput("o_ctrl1", 32'(b), 32'(e.b));
      end
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding prediction
  always @(negedge i_CLK) begin
    if (!i_RST) begin
      if (o_data_valid) expectEvent(EV_DATA, o_data, 8'h00);
      if (o_ctrl_valid) expectEvent(EV_CTRL, o_ctrl0, o_ctrl1);
      if (o_frame_err)  expectEvent(EV_ERR, 8'h00, 8'h00);
    end
  end

  function automatic logic [7:0] lastByte();
    logic [7:0] v = 8'h00;
    int n = m_bits.size();
    for (int i = 0; i < 8; i++) begin
      if (n - 8 + i >= 0) v = {v[6:0], m_bits[n - 8 + i]};
      else                v = {v[6:0], 1'b0};
    end
    return v;
  endfunction

  task automatic pushEvent(input ev_kind_t k, input logic [7:0] a, input logic [7:0] b, input int when);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.b    = b;
    e.when = when;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_CLK);
    #1;
  endtask

  task automatic startFrame(input bit rs);
    i_hcms_regsel = rs;
    m_regsel = rs;
    m_bits.delete();
    tick(4);
    i_hcms_ncs = 1'b0;
    tick(4);
  endtask

  // Raw edges are driven just after a clock edge, so the response lands 4 cycles later
  task automatic shiftBit(input bit b);
    i_hcms_data = b;
    tick(4);
    i_hcms_clock = 1'b1;
    m_bits.push_back(b);
    if (!m_regsel && (m_bits.size() % 8 == 0) && m_bits.size() <= 63)
      pushEvent(EV_DATA, lastByte(), 8'h00, cyc + 4);
    tick(4);
    i_hcms_clock = 1'b0;
  endtask

  task automatic endFrame();
    logic [7:0] v;
    int n;
    tick(4);
    i_hcms_ncs = 1'b1;
    n = m_bits.size();
    if (n != 0) begin
      if (n > 63 || (n % 8) != 0) begin
        pushEvent(EV_ERR, 8'h00, 8'h00, cyc + 4);
      end else if (m_regsel) begin
        v = lastByte();
        if (v[7]) m_ctrl1 = v;
        else      m_ctrl0 = v;
        pushEvent(EV_CTRL, m_ctrl0, m_ctrl1, cyc + 4);
      end
    end
    tick(8);
    checkOutput("o_ctrl0 after frame", 32'(o_ctrl0), 32'(m_ctrl0));
    checkOutput("o_ctrl1 after frame", 32'(o_ctrl1), 32'(m_ctrl1));
  endtask

  task automatic applyStimulus(input bit rs, input int n, input logic [63:0] bits);
    startFrame(rs);
    for (int i = n - 1; i >= 0; i--) shiftBit(bits[i]);
    endFrame();
  endtask

  initial begin
    int n;
    bit rs;
    logic [63:0] bits;

    i_RST = 1'b1;
    i_hcms_data = 1'b0;
    i_hcms_clock = 1'b0;
    i_hcms_regsel = 1'b0;
    i_hcms_ncs = 1'b1;
    i_hcms_reset = 1'b1;
    m_ctrl0 = 8'h00;
    m_ctrl1 = 8'h80;
    tick(2);
    i_RST = 1'b0;
    tick(1);
    checkOutput("reset o_ctrl0", 32'(o_ctrl0), 32'h00);
    checkOutput("reset o_ctrl1", 32'(o_ctrl1), 32'h80);
    checkOutput("reset o_sleep_n", 32'(o_sleep_n), 32'h0);
    checkOutput("reset o_data", 32'(o_data), 32'h00);
    checkOutput("reset pulses", 32'({o_data_valid, o_ctrl_valid, o_frame_err}), 32'h0);
    tick(4);

    $display("[TB] control writes");
    applyStimulus(1'b1, 8, 64'h81);
    applyStimulus(1'b1, 8, 64'h7F);
    checkOutput("o_brightness", 32'(o_brightness), 32'hF);
    checkOutput("o_peak_current", 32'(o_peak_current), 32'h3);
    checkOutput("o_sleep_n", 32'(o_sleep_n), 32'h1);

    $display("[TB] 24-bit data stream");
    applyStimulus(1'b0, 24, 64'h010280);

    $display("[TB] malformed frame");
    applyStimulus(1'b1, 5, 64'h15);

    $display("[TB] display reset mid-frame");
    startFrame(1'b0);
    shiftBit(1'b1);
    shiftBit(1'b0);
    shiftBit(1'b1);
    shiftBit(1'b0);
    tick(2);
    i_hcms_reset = 1'b0;
    m_bits.delete();
    m_ctrl0 = 8'h00;
    m_ctrl1 = 8'h80;
    tick(8);
    i_hcms_reset = 1'b1;
    tick(8);
    i_hcms_ncs = 1'b1;
    tick(8);
    checkOutput("reload o_ctrl0", 32'(o_ctrl0), 32'h00);
    checkOutput("reload o_ctrl1", 32'(o_ctrl1), 32'h80);
    applyStimulus(1'b0, 8, 64'hA5);
    checkOutput("o_data after reset", 32'(o_data), 32'hA5);

    $display("[TB] loopback sequence");
    applyStimulus(1'b1, 8, 64'h81);
    applyStimulus(1'b1, 8, 64'h7F);
    for (int k = 1; k < 8; k++) applyStimulus(1'b0, 8, 64'(8'h01 << k));

    $display("[TB] randomized frames");
    for (int f = 0; f < 40; f++) begin
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) n = 8 * int'($urandom_range(0, 5));
      else                           n = int'($urandom_range(0, 40));
      bits = {$urandom, $urandom};
      applyStimulus(rs, n, bits);
    end

    tick(20);
    checkOutput("pending predictions", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
